// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// Module : mem_lsu_pkg
// Brief  : Shared size encodings, FSM state type and lane constants for the LSU
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int LANE_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Encoding 3 is illegal; it maps to 4 so the range check stays well formed.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        logic [2:0] nb;
        case (size)
            SZ_B:    nb = 3'd1;
            SZ_H:    nb = 3'd2;
            default: nb = 3'd4;
        endcase
        return nb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_if.sv
// ============================================================================
// Module : mem_lsu_if
// Brief  : Core request/response handshake plus data-memory port of the LSU
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_lsu_if #(
    parameter int DEPTH = 32
) ();
    localparam int AW = $clog2(DEPTH) + 2;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;

    // Environment side: core pipeline plus the data memory.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_we, mem_wmask, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_we, mem_wmask, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// ============================================================================
// Module : mem_lsu_align
// Brief  : Combinational lane steering for stores and extraction/extension for loads
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  wire logic [1:0]  off,
    input  wire logic [1:0]  size,
    input  wire logic [31:0] wdata,
    input  wire logic [31:0] buf_lo,
    input  wire logic [31:0] buf_hi,
    input  wire logic        is_unsigned,
    output logic      [63:0] data64,
    output logic      [7:0]  mask8,
    output logic             crossing,
    output logic      [31:0] rdata
);

    logic [2:0]  w_nbytes;
    logic [4:0]  w_sh;
    logic [7:0]  w_base_mask;
    logic [31:0] w_v;

    assign w_nbytes = size_nbytes(size);
    assign w_sh     = {off, 3'b000};

    // Two adjacent words form a 64-bit window; the shift lands bytes in their lanes.
    assign data64   = {32'b0, wdata} << w_sh;
    assign crossing = ({1'b0, off} + w_nbytes) > 3'd4;

    always_comb begin
        case (size)
            SZ_B:    w_base_mask = 8'h01;
            SZ_H:    w_base_mask = 8'h03;
            default: w_base_mask = 8'h0F;
        endcase
    end

    assign mask8 = w_base_mask << off;

    assign w_v = 32'({buf_hi, buf_lo} >> w_sh);

    always_comb begin
        case (size)
            SZ_B:    rdata = is_unsigned ? {24'b0, w_v[7:0]}
                                         : {{24{w_v[7]}}, w_v[7:0]};
            SZ_H:    rdata = is_unsigned ? {16'b0, w_v[15:0]}
                                         : {{16{w_v[15]}}, w_v[15:0]};
            default: rdata = w_v;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module : mem_lsu
// Brief  : Load/store initiator with word splitting, range check and load extension
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    mem_lsu_if.slave  bus
);

    localparam int          AW    = $clog2(DEPTH) + 2;
    localparam logic [32:0] LIMIT = 33'(DEPTH * LANE_BYTES);

    lsu_state_t       r_state;
    lsu_state_t       w_next;

    logic [AW-1:0]    r_addr;
    logic [1:0]       r_size;
    logic             r_we;
    logic             r_uns;
    logic             r_err;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_buf_lo;
    logic [WIDTH-1:0] r_buf_hi;

    logic             w_accept;
    logic             w_illegal;
    logic [32:0]      w_last;
    logic [63:0]      w_data64;
    logic [7:0]       w_mask8;
    logic             w_cross;
    logic [31:0]      w_ext;
    logic [AW-1:0]    w_word0;

    logic             w_req_ready;
    logic             w_resp_valid;
    logic [31:0]      w_resp_rdata;
    logic             w_resp_err;
    logic [AW-1:0]    w_mem_addr;
    logic             w_mem_we;
    logic [3:0]       w_mem_wmask;
    logic [31:0]      w_mem_wdata;

    assign w_accept = bus.req_valid && (r_state == IDLE);

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign w_last    = {1'b0, bus.req_addr} + 33'(size_nbytes(bus.req_size)) - 33'd1;
    assign w_illegal = (bus.req_size == 2'd3) || (w_last >= LIMIT);

    assign w_word0 = {r_addr[AW-1:2], 2'b00};

    mem_lsu_align u_align (
        .off         (r_addr[1:0]),
        .size        (r_size),
        .wdata       (r_wdata),
        .buf_lo      (r_buf_lo),
        .buf_hi      (r_buf_hi),
        .is_unsigned (r_uns),
        .data64      (w_data64),
        .mask8       (w_mask8),
        .crossing    (w_cross),
        .rdata       (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_illegal ? RESP : ACC0;
            ACC0: w_next = w_cross ? ACC1 : RESP;
            ACC1: w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_we     <= 1'b0;
            r_uns    <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
            r_buf_lo <= '0;
            r_buf_hi <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.req_addr[AW-1:0];
                r_size  <= bus.req_size;
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_err   <= w_illegal;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == ACC0 && !r_we) r_buf_lo <= bus.mem_rdata;
            if (r_state == ACC1 && !r_we) r_buf_hi <= bus.mem_rdata;
        end
    end

    always_comb begin
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_rdata = '0;
        w_resp_err   = 1'b0;
        w_mem_addr   = '0;
        w_mem_we     = 1'b0;
        w_mem_wmask  = '0;
        w_mem_wdata  = '0;
        case (r_state)
            IDLE: w_req_ready = 1'b1;
            ACC0: begin
                w_mem_addr = w_word0;
                if (r_we) begin
                    w_mem_we    = 1'b1;
                    w_mem_wmask = w_mask8[3:0];
                    w_mem_wdata = w_data64[31:0];
                end
            end
            ACC1: begin
                w_mem_addr = w_word0 + AW'(LANE_BYTES);
                if (r_we) begin
                    w_mem_we    = 1'b1;
                    w_mem_wmask = w_mask8[7:4];
                    w_mem_wdata = w_data64[63:32];
                end
            end
            RESP: begin
                w_resp_valid = 1'b1;
                w_resp_err   = r_err;
                w_resp_rdata = (r_err || r_we) ? 32'd0 : w_ext;
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = w_resp_rdata;
    assign bus.resp_err   = w_resp_err;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_wmask  = w_mem_wmask;
    assign bus.mem_wdata  = w_mem_wdata;

endmodule

`default_nettype wire
